mem_responder: RTL and testbench

Memory-side responder for the multicycle core's bus: the target end of the IAD/IDT instruction port and the MREQ/WRITE/DAD/DDT data port that the core datapath drives. It holds a word-organised RAM and returns instruction words with fixed one-cycle latency. Data requests are serviced through a wait-state FSM with a one-cycle ACK pulse, so the core's load-wait and stall logic sees realistic latency. Stores are byte-lane merged. Loads return lane-aligned, zero-extended data; the core does sign extension.

---
 rtl/mem_resp_pkg.sv | 52 +++++
 rtl/mem_lane.sv | 49 ++++
 rtl/mem_responder.sv | 149 ++++++++++++++
 tb/tb_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types for the memory-side responder: FSM states, SIZE codes,
// request payload and byte-lane decode.
package mem_resp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [BE_W-1:0] be;
        logic            misalign;
    } lane_ctl_t;

    // Byte enables for an access; a misaligned access enables no lanes.
    function automatic lane_ctl_t lane_ctl(input logic [1:0] size, input logic [1:0] a);
        lane_ctl_t r;
        r.be       = '0;
        r.misalign = 1'b0;
        case (size)
            SZ_B: r.be = 4'b0001 << a;
            SZ_H: begin
                r.be       = a[1] ? 4'b1100 : 4'b0011;
                r.misalign = a[0];
            end
            default: begin
                r.be       = 4'b1111;
                r.misalign = (a != 2'b00);
            end
        endcase
        if (r.misalign) begin
            r.be = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane datapath: store replication/merge into the old word and
// zero-extended load extraction from it.
module mem_lane
    import mem_resp_pkg::*;
(
    input  logic [1:0]        size_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] old_word_i,
    output logic [BE_W-1:0]   be_c_o,
    output logic              misalign_c_o,
    output logic [DATA_W-1:0] merged_c_o,
    output logic [DATA_W-1:0] rdata_c_o
);

    lane_ctl_t         ctl;
    logic [DATA_W-1:0] repl;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        ctl          = lane_ctl(size_i, addr_lo_i);
        repl         = wdata_i;
        shifted      = old_word_i >> {addr_lo_i, 3'b000};
        merged_c_o   = old_word_i;
        rdata_c_o    = old_word_i;
        be_c_o       = ctl.be;
        misalign_c_o = ctl.misalign;

        case (size_i)
            SZ_B:    repl = {4{wdata_i[7:0]}};
            SZ_H:    repl = {2{wdata_i[15:0]}};
            default: repl = wdata_i;
        endcase

        for (int i = 0; i < int'(BE_W); i++) begin
            merged_c_o[8*i +: 8] = ctl.be[i] ? repl[8*i +: 8] : old_word_i[8*i +: 8];
        end

        case (size_i)
            SZ_B:    rdata_c_o = {24'h0, shifted[7:0]};
            SZ_H:    rdata_c_o = {16'h0, shifted[15:0]};
            default: rdata_c_o = old_word_i;
        endcase
        if (ctl.misalign) begin
            rdata_c_o = '0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Bus target for the multicycle core: registered instruction port plus a
// wait-state data port with byte-lane stores and a one-cycle ACK.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] IAD,
    output logic [DATA_W-1:0] IDT,
    input  logic              MREQ,
    input  logic              WRITE,
    input  logic [1:0]        SIZE,
    input  logic [DATA_W-1:0] DAD,
    input  logic [DATA_W-1:0] DDT_in,
    output logic [DATA_W-1:0] DDT_out,
    output logic              ACK,
    output logic              ERR
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] ddt_q, ddt_d;
    logic [DATA_W-1:0] idt_q;

    req_t              in_req_c;
    req_t              cur_req_c;
    logic [IDX_W-1:0]  widx_c;
    logic [DATA_W-1:0] old_word_c;
    logic [BE_W-1:0]   be_c;
    logic              misalign_c;
    logic [DATA_W-1:0] merged_c;
    logic [DATA_W-1:0] rdata_c;
    logic              commit_c;
    logic              we_c;
    logic              unused_c;

    // In IDLE with zero wait states the commit uses the request being sampled.
    always_comb begin
        in_req_c.write = WRITE;
        in_req_c.size  = SIZE;
        in_req_c.addr  = DAD;
        in_req_c.wdata = DDT_in;
        cur_req_c      = (state_q == ST_IDLE) ? in_req_c : req_q;
    end

    assign widx_c     = cur_req_c.addr[ADDR_W-1:2];
    assign old_word_c = mem_q[widx_c];

    mem_lane u_lane (
        .size_i       (cur_req_c.size),
        .addr_lo_i    (cur_req_c.addr[1:0]),
        .wdata_i      (cur_req_c.wdata),
        .old_word_i   (old_word_c),
        .be_c_o       (be_c),
        .misalign_c_o (misalign_c),
        .merged_c_o   (merged_c),
        .rdata_c_o    (rdata_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        ddt_d    = '0;
        commit_c = 1'b0;
        we_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MREQ) begin
                    req_d = in_req_c;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = ST_RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (commit_c) begin
            ack_d = 1'b1;
            err_d = misalign_c;
            ddt_d = cur_req_c.write ? '0 : rdata_c;
            we_c  = cur_req_c.write && (|be_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ddt_q   <= '0;
            idt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            ddt_q   <= ddt_d;
            idt_q   <= mem_q[IAD[ADDR_W-1:2]];
        end
    end

    // RAM has no reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (!rst && we_c) begin
            mem_q[widx_c] <= merged_c;
        end
    end

    assign IDT     = idt_q;
    assign DDT_out = ddt_q;
    assign ACK     = ack_q;
    assign ERR     = err_q;

    assign unused_c = ^{IAD[DATA_W-1:ADDR_W], IAD[1:0], cur_req_c.addr[DATA_W-1:ADDR_W]};

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a word-map model and per-cycle compare.
module tb_mem_responder;

    localparam int unsigned W0 = 2;
    localparam logic [1:0] SZB = 2'b00;
    localparam logic [1:0] SZH = 2'b01;
    localparam logic [1:0] SZW = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] iad = 32'h20;
    logic [31:0] idt;
    logic        mreq = 1'b0, wr = 1'b0;
    logic [1:0]  sz = 2'b00;
    logic [31:0] dad = 32'h0, ddt_in = 32'h0, ddt_out;
    logic        ack, err;

    logic [31:0] iad1 = 32'h0;
    logic [31:0] idt1;
    logic        mreq1 = 1'b0, wr1 = 1'b0;
    logic [1:0]  sz1 = 2'b10;
    logic [31:0] dad1 = 32'h0, ddt_in1 = 32'h0, ddt_out1;
    logic        ack1, err1;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(12), .WAIT_CYCLES(W0)) dut (
        .clk(clk), .rst(rst), .IAD(iad), .IDT(idt), .MREQ(mreq), .WRITE(wr),
        .SIZE(sz), .DAD(dad), .DDT_in(ddt_in), .DDT_out(ddt_out), .ACK(ack), .ERR(err)
    );

    mem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0w (
        .clk(clk), .rst(rst), .IAD(iad1), .IDT(idt1), .MREQ(mreq1), .WRITE(wr1),
        .SIZE(sz1), .DAD(dad1), .DDT_in(ddt_in1), .DDT_out(ddt_out1), .ACK(ack1), .ERR(err1)
    );

    typedef struct {
        int          cyc;
        logic        write;
        int          idx;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] nword;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] mm [int];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        rst_s = 1'b1;
    logic [31:0] iad_s = 32'h0;
    logic [31:0] last_ddt = 32'h0;
    logic [31:0] last_idt_commit = 32'h0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Access semantics from byte counts and offsets.
    function automatic void model(input logic write, input logic [1:0] size,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] old, output logic e,
                                  output logic [31:0] rd, output logic [31:0] nw);
        int          nb, off;
        logic [31:0] mask;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off  = int'(addr % 32'd4);
        mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nb)) - 64'd1);
        e    = (off % nb) != 0;
        rd   = 32'h0;
        nw   = old;
        if (!e) begin
            if (write) nw = (old & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            else       rd = (old >> (8 * off)) & mask;
        end
    endfunction

    task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic        me;
        logic [31:0] mrd, mnw, old;
        int          idx;
        idx = int'((a >> 2) & 32'h3FF);
        old = mm.exists(idx) ? mm[idx] : 32'h0;
        model(w, s, a, d, old, me, mrd, mnw);
        e.cyc = cyc + 1 + int'(W0);
        e.write = w; e.idx = idx; e.err = me; e.rdata = mrd; e.nword = mnw;
        expq.push_back(e);
        mreq = 1'b1; wr = w; sz = s; dad = a; ddt_in = d;
        @(negedge clk);
        mreq = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        issue(w, s, a, d);
        repeat (W0 + 2) @(negedge clk);
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
        iad_s <= iad;
    end

    // Per-cycle compare of the W0 instance against the model.
    always @(negedge clk) begin
        int   widx;
        logic exp_ack;
        if (rst_s) begin
            chk("rst_ack", 32'(ack), 32'h0);
            chk("rst_err", 32'(err), 32'h0);
            chk("rst_ddt_out", ddt_out, 32'h0);
            chk("rst_idt", idt, 32'h0);
            expq.delete();
        end else begin
            widx = int'((iad_s >> 2) & 32'h3FF);
            if (mm.exists(widx)) chk("idt", idt, mm[widx]);
            exp_ack = (expq.size() > 0) && (expq[0].cyc == cyc);
            chk("ack", 32'(ack), 32'(exp_ack));
            if (exp_ack) begin
                chk("err", 32'(err), 32'(expq[0].err));
                chk("ddt_out", ddt_out, expq[0].rdata);
                last_ddt        = ddt_out;
                last_err        = err;
                last_idt_commit = idt;
                if (expq[0].write) mm[expq[0].idx] = expq[0].nword;
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        int acks;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, SZW, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, SZW, 32'h10, 32'h0);
        chk("lit_ld_word", last_ddt, 32'hDEADBEEF);
        chk("lit_ld_word_err", 32'(last_err), 32'h0);
        chk("lit_model_word4", mm[4], 32'hDEADBEEF);

        do_req(1'b1, SZW, 32'h20, 32'h11223344);
        do_req(1'b1, SZB, 32'h23, 32'h000000AA);
        chk("lit_idt_collide_old", last_idt_commit, 32'h11223344);
        chk("lit_idt_after_store", idt, 32'hAA223344);
        do_req(1'b1, SZH, 32'h20, 32'h0000BBCC);
        do_req(1'b0, SZW, 32'h20, 32'h0);
        chk("lit_merge_word", last_ddt, 32'hAA22BBCC);
        do_req(1'b0, SZB, 32'h23, 32'h0);
        chk("lit_byte_load", last_ddt, 32'h000000AA);

        do_req(1'b1, SZH, 32'h21, 32'h00009999);
        chk("lit_mis_store_err", 32'(last_err), 32'h1);
        do_req(1'b0, SZW, 32'h22, 32'h0);
        chk("lit_mis_load_err", 32'(last_err), 32'h1);
        chk("lit_mis_load_ddt", last_ddt, 32'h0);
        do_req(1'b0, SZW, 32'h20, 32'h0);
        chk("lit_mis_unchanged", last_ddt, 32'hAA22BBCC);

        do_req(1'b1, SZW, 32'h1020, 32'hCAFEF00D);
        do_req(1'b0, SZW, 32'h020, 32'h0);
        chk("lit_wrap_load", last_ddt, 32'hCAFEF00D);
        chk("lit_wrap_idt", idt, 32'hCAFEF00D);
        do_req(1'b0, 2'b11, 32'h10, 32'h0);
        chk("lit_size11_word", last_ddt, 32'hDEADBEEF);
        do_req(1'b0, SZH, 32'h12, 32'h0);
        chk("lit_half_upper", last_ddt, 32'h0000DEAD);

        // Reset during WAIT abandons the store.
        do_req(1'b1, SZW, 32'h30, 32'h12345678);
        issue(1'b1, SZW, 32'h30, 32'h55555555);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("lit_rst_ack", 32'(ack), 32'h0);
        chk("lit_rst_idt", idt, 32'h0);
        chk("lit_rst_ddt", ddt_out, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_req(1'b0, SZW, 32'h30, 32'h0);
        chk("lit_rst_no_commit", last_ddt, 32'h12345678);

        // Zero-wait instance with MREQ held high.
        mreq1 = 1'b1; wr1 = 1'b1; sz1 = SZW; dad1 = 32'h40; ddt_in1 = 32'h0BADF00D;
        @(negedge clk);
        mreq1 = 1'b0;
        repeat (2) @(negedge clk);
        mreq1 = 1'b1; wr1 = 1'b0;
        acks = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("w0_ack_pattern", 32'(ack1), ((k - 1) % 2 == 0) ? 32'h1 : 32'h0);
            if (ack1) begin
                chk("w0_ddt_out", ddt_out1, 32'h0BADF00D);
                chk("w0_err", 32'(err1), 32'h0);
                acks++;
            end
        end
        mreq1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("w0_ack_idle", 32'(ack1), 32'h0);
        end
        chk("w0_ack_count", 32'(acks), 32'd4);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
